// File: rtl/hit_combiner.sv
// rtl/hit_combiner.sv - odometer walk over per-layer hit memories, one hit word per layer per beat
// HITCOMB_WILDCARD_EN: empty layers become zero wildcard slices instead of aborting the event.
module hit_combiner #(
  parameter int NLAYERS = 6,
  parameter int WIDTH   = 19,
  parameter int SETTLE  = 2,
  parameter int MAXCOMB = 4096
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NLAYERS*WIDTH-1:0]   hm_dout,
  input  logic [NLAYERS-1:0]         hm_last,
  input  logic [NLAYERS-1:0]         hm_empty,
  output logic [NLAYERS-1:0]         hm_next,
  output logic [NLAYERS-1:0]         hm_rewind,
  output logic [NLAYERS*WIDTH-1:0]   comb_data,
  output logic [NLAYERS-1:0]         comb_mask,
  output logic                       comb_valid,
  output logic                       comb_last,
  input  logic                       comb_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       trunc,
  output logic [15:0]                ncomb
);

  typedef enum logic [2:0] {
    S_IDLE, S_REWIND, S_SETTLE, S_EMIT, S_ADVANCE, S_DONE
  } state_t;

  state_t                     state;
  logic [7:0]                 settle_cnt;
  logic                       first_pass;
  logic                       cap_hit;
  logic                       settle_done;
  logic                       capture;
  logic                       at_cap;
  logic                       abort;
  logic                       found;
  logic [NLAYERS-1:0]         wild;
  logic [NLAYERS-1:0]         last_eff;
  logic [NLAYERS-1:0]         adv_next;
  logic [NLAYERS-1:0]         adv_rewind;
  logic [NLAYERS*WIDTH-1:0]   dout_eff;

`ifdef HITCOMB_WILDCARD_EN
  assign wild  = hm_empty;
  assign abort = 1'b0;
`else
  assign wild  = '0;
  assign abort = |hm_empty;
`endif

  assign last_eff    = hm_last | wild;
  assign at_cap      = (ncomb == 16'(MAXCOMB - 1));
  assign settle_done = (state == S_SETTLE) && (settle_cnt == 8'(SETTLE - 1));
  assign capture     = settle_done && !(first_pass && abort);

  always_comb begin
    for (int i = 0; i < NLAYERS; i++) begin
      dout_eff[i*WIDTH +: WIDTH] = wild[i] ? '0 : hm_dout[i*WIDTH +: WIDTH];
    end
  end

  // Odometer step: bump the lowest non-final layer, rewind every layer below it.
  always_comb begin
    adv_next   = '0;
    adv_rewind = '0;
    found      = 1'b0;
    for (int i = 0; i < NLAYERS; i++) begin
      if (!found) begin
        if (!last_eff[i]) begin
          adv_next[i] = 1'b1;
          found       = 1'b1;
        end else begin
          adv_rewind[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      first_pass <= 1'b0;
      cap_hit    <= 1'b0;
      hm_next    <= '0;
      hm_rewind  <= '0;
      comb_data  <= '0;
      comb_valid <= 1'b0;
      comb_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      trunc      <= 1'b0;
      ncomb      <= '0;
    end else begin
      hm_next   <= '0;
      hm_rewind <= '0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ncomb      <= '0;
            trunc      <= 1'b0;
            busy       <= 1'b1;
            first_pass <= 1'b1;
            hm_rewind  <= '1;
            state      <= S_REWIND;
          end
        end
        S_REWIND: begin
          settle_cnt <= '0;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_done) begin
            first_pass <= 1'b0;
            if (capture) begin
              comb_data  <= dout_eff;
              comb_valid <= 1'b1;
              comb_last  <= (&last_eff) | at_cap;
              cap_hit    <= at_cap & ~(&last_eff);
              state      <= S_EMIT;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        S_EMIT: begin
          if (comb_ready) begin
            comb_valid <= 1'b0;
            comb_last  <= 1'b0;
            if (ncomb != 16'hFFFF) ncomb <= ncomb + 16'd1;
            if (comb_last) begin
              if (cap_hit) trunc <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              hm_next   <= adv_next;
              hm_rewind <= adv_rewind;
              state     <= S_ADVANCE;
            end
          end
        end
        S_ADVANCE: begin
          settle_cnt <= '0;
          state      <= S_SETTLE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef HITCOMB_WILDCARD_EN
  always_ff @(posedge clock) begin
    if (reset)        comb_mask <= '0;
    else if (capture) comb_mask <= hm_empty;
  end
`else
  assign comb_mask = '0;
`endif

endmodule

// File: tb/tb_hit_combiner.sv
// tb/tb_hit_combiner.sv - scoreboard bench for hit_combiner with a hit-memory model
// Two instances share the memory model: default cap (a) and MAXCOMB=4 (b).
module tb_hit_combiner;
  localparam int NL    = 6;
  localparam int W     = 19;
  localparam int ST    = 2;
  localparam int CAP_A = 4096;
  localparam int CAP_B = 4;

  typedef struct {
    logic [NL*W-1:0] data;
    logic [NL-1:0]   mask;
    logic            last;
  } beat_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset, start_a, start_b, comb_ready, sel;
  logic [NL*W-1:0] hm_dout;
  logic [NL-1:0]   hm_last, hm_empty;
  logic [NL-1:0]   next_a, rew_a, mask_a, next_b, rew_b, mask_b;
  logic [NL*W-1:0] data_a, data_b;
  logic            valid_a, last_a, busy_a, done_a, trunc_a;
  logic            valid_b, last_b, busy_b, done_b, trunc_b;
  logic [15:0]     ncomb_a, ncomb_b;

  hit_combiner #(.NLAYERS(NL), .WIDTH(W), .SETTLE(ST), .MAXCOMB(CAP_A)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .hm_dout(hm_dout), .hm_last(hm_last),
    .hm_empty(hm_empty), .hm_next(next_a), .hm_rewind(rew_a), .comb_data(data_a),
    .comb_mask(mask_a), .comb_valid(valid_a), .comb_last(last_a), .comb_ready(comb_ready),
    .busy(busy_a), .done(done_a), .trunc(trunc_a), .ncomb(ncomb_a));

  hit_combiner #(.NLAYERS(NL), .WIDTH(W), .SETTLE(ST), .MAXCOMB(CAP_B)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .hm_dout(hm_dout), .hm_last(hm_last),
    .hm_empty(hm_empty), .hm_next(next_b), .hm_rewind(rew_b), .comb_data(data_b),
    .comb_mask(mask_b), .comb_valid(valid_b), .comb_last(last_b), .comb_ready(comb_ready),
    .busy(busy_b), .done(done_b), .trunc(trunc_b), .ncomb(ncomb_b));

  logic [NL-1:0]   hm_next, hm_rewind, comb_mask;
  logic [NL*W-1:0] comb_data;
  logic            comb_valid, comb_last, busy, done, trunc;
  logic [15:0]     ncomb;
  assign hm_next    = sel ? next_b  : next_a;
  assign hm_rewind  = sel ? rew_b   : rew_a;
  assign comb_mask  = sel ? mask_b  : mask_a;
  assign comb_data  = sel ? data_b  : data_a;
  assign comb_valid = sel ? valid_b : valid_a;
  assign comb_last  = sel ? last_b  : last_a;
  assign busy       = sel ? busy_b  : busy_a;
  assign done       = sel ? done_b  : done_a;
  assign trunc      = sel ? trunc_b : trunc_a;
  assign ncomb      = sel ? ncomb_b : ncomb_a;

  function automatic logic [W-1:0] hit_word(input int layer, input int p);
    return {3'(layer), 16'(p + 256)};
  endfunction

  // Hit memory: pointer moves on the edge after a pulse, dout/last one edge later.
  int cnt [NL];
  int ptr [NL] = '{default: 0};
  always @(posedge clock) begin
    for (int i = 0; i < NL; i++) begin
      if (hm_rewind[i])    ptr[i] <= 0;
      else if (hm_next[i]) ptr[i] <= ptr[i] + 1;
      hm_dout[i*W +: W] <= hit_word(i, ptr[i]);
      hm_last[i]        <= (ptr[i] >= cnt[i] - 1);
    end
  end
  always_comb begin
    for (int i = 0; i < NL; i++) hm_empty[i] = (cnt[i] == 0);
  end

  int    n_chk = 0;
  int    n_fail = 0;
  beat_t sb[$];
  int    exp_beats;
  logic  exp_trunc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_counts(input int c0, c1, c2, c3, c4, c5);
    cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3; cnt[4] = c4; cnt[5] = c5;
  endtask

  task automatic build_expected(input int cap);
    int    idx [NL];
    int    nb;
    int    k;
    logic  all_last;
    beat_t b;
    sb.delete();
    exp_trunc = 1'b0;
    exp_beats = 0;
    nb = 0;
    for (int i = 0; i < NL; i++) idx[i] = 0;
`ifndef HITCOMB_WILDCARD_EN
    for (int i = 0; i < NL; i++) if (cnt[i] == 0) return;
`endif
    forever begin
      all_last = 1'b1;
      for (int i = 0; i < NL; i++) begin
        if (cnt[i] == 0) begin
          b.data[i*W +: W] = '0;
          b.mask[i] = 1'b1;
        end else begin
          b.data[i*W +: W] = hit_word(i, idx[i]);
          b.mask[i] = 1'b0;
          if (idx[i] < cnt[i] - 1) all_last = 1'b0;
        end
      end
      nb++;
      b.last = all_last || (nb == cap);
      sb.push_back(b);
      if (b.last) begin
        exp_trunc = !all_last;
        break;
      end
      k = 0;
      while (idx[k] >= cnt[k] - 1) begin
        idx[k] = 0;
        k++;
      end
      idx[k]++;
    end
    exp_beats = nb;
  endtask

  task automatic run_event(input logic use_b, input string tag, input int stall_beat,
                           input int stall_len, input int reset_beat);
    int              k, prev_k, beats, stall_left, since;
    logic            fin, seen, pend_last, stalled_this, prev_stalled;
    beat_t           e;
    logic [NL*W-1:0] held;
    sel = use_b;
    build_expected(use_b ? CAP_B : CAP_A);
    @(negedge clock);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    comb_ready = 1'b1;
    k = 0; prev_k = 0; beats = 0; stall_left = stall_len; since = 0;
    fin = 0; seen = 0; pend_last = 0; stalled_this = 0; prev_stalled = 0;
    while (!fin && k < 3000) begin
      @(negedge clock);
      k++;
      start_a = 1'b0;
      start_b = 1'b0;
      chk({tag, " pulse protocol"},
          {$onehot0(hm_next), (hm_next & hm_rewind) == '0, (hm_next & hm_last) == '0}, 3'b111);
      if (k == 1) begin
        chk({tag, " busy after start"}, busy, 1'b1);
        chk({tag, " trunc cleared"}, trunc, 1'b0);
      end
      if (reset_beat > 0 && beats == reset_beat) begin
        since++;
        if (since == 2) reset = 1'b1;
        else if (since == 3) begin
          chk({tag, " outputs after reset"},
              {comb_valid, comb_last, busy, done, trunc, ncomb, hm_next, hm_rewind, comb_mask}, '0);
          chk({tag, " data after reset"}, comb_data, '0);
        end else if (since > 3 && since < 7) chk({tag, " no pulses in reset"}, {hm_next, hm_rewind}, '0);
        else if (since == 7) begin
          reset = 1'b0;
          fin = 1'b1;
        end
        continue;
      end
      if (pend_last) begin
        chk({tag, " done after last accept"}, done, 1'b1);
        fin = 1'b1;
      end else if (done) begin
        chk({tag, " abort done timing"}, k, (exp_beats == 0) ? ST + 2 : -1);
        fin = 1'b1;
      end else if (comb_valid) begin
        if (!seen) begin
          seen = 1'b1;
          held = comb_data;
          if (beats == 0) chk({tag, " first valid latency"}, k, ST + 2);
          else if (!prev_stalled) chk({tag, " beat spacing"}, k - prev_k, ST + 2);
          prev_k = k;
        end
        if (beats == stall_beat && stall_left > 0) begin
          comb_ready = 1'b0;
          stall_left--;
          stalled_this = 1'b1;
          chk({tag, " stall data stable"}, comb_data, held);
          chk({tag, " no next in stall"}, hm_next, '0);
        end else begin
          comb_ready = 1'b1;
          chk({tag, " beat expected"}, sb.size() > 0, 1'b1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " data"}, comb_data, e.data);
            chk({tag, " mask"}, comb_mask, e.mask);
            chk({tag, " last"}, comb_last, e.last);
            pend_last = e.last;
          end
          beats++;
          seen = 1'b0;
          prev_stalled = stalled_this;
          stalled_this = 1'b0;
        end
      end
    end
    chk({tag, " event finished"}, fin, 1'b1);
    if (reset_beat == 0) begin
      chk({tag, " beat count"}, beats, exp_beats);
      chk({tag, " ncomb"}, ncomb, 16'(exp_beats));
      chk({tag, " trunc"}, trunc, exp_trunc);
      chk({tag, " busy low at done"}, busy, 1'b0);
      @(negedge clock);
      chk({tag, " done single pulse"}, done, 1'b0);
    end
    sb.delete();
    comb_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; comb_ready = 1'b0; sel = 1'b0;
    set_counts(1, 1, 1, 1, 1, 1);
    repeat (3) @(negedge clock);
    chk("reset outputs a", {valid_a, last_a, busy_a, done_a, trunc_a, ncomb_a, next_a, rew_a, mask_a}, '0);
    chk("reset data a", data_a, '0);
    chk("reset outputs b", {valid_b, last_b, busy_b, done_b, trunc_b, ncomb_b, next_b, rew_b, mask_b}, '0);
    reset = 1'b0;
    comb_ready = 1'b1;
    @(negedge clock);

    run_event(1'b0, "single", -1, 0, 0);
    set_counts(2, 3, 1, 1, 1, 1);
    run_event(1'b0, "odometer", -1, 0, 0);
    set_counts(2, 2, 2, 0, 2, 2);
    run_event(1'b0, "empty layer3", -1, 0, 0);
    set_counts(3, 3, 1, 1, 1, 1);
    run_event(1'b1, "cap", -1, 0, 0);
    set_counts(1, 1, 1, 1, 1, 1);
    run_event(1'b1, "cap cleared", -1, 0, 0);
    set_counts(2, 3, 1, 1, 1, 1);
    run_event(1'b0, "stall", 1, 5, 0);
    run_event(1'b0, "mid reset", -1, 0, 2);
    run_event(1'b0, "after reset", -1, 0, 0);
    set_counts(0, 0, 0, 0, 0, 0);
    run_event(1'b0, "all empty", -1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hit_combiner.md
# hit_combiner

Downstream consumer of the per-layer hit memories. After an event's hits are stored, it walks every layer's hit list as an odometer and emits one combination per output beat: one hit word per layer. The combination stream feeds the track-fit pipeline. Per-layer memory pointers are driven only through each memory's `next`/rewind controls, and every advance is followed by a fixed read-settle wait.

## Interface
- `NLAYERS`, 6: number of hit-memory layers.
- `WIDTH`, 19: hit word width.
- `SETTLE`, 2: cycles from a `next`/rewind pulse until that layer's `dout`/`last` are valid.
- `MAXCOMB`, 4096: combination cap per event.
- `clock`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high; returns the block to IDLE.
- `start`  in  1: one-cycle pulse; event hits are loaded, begin combining.
- `hm_dout`  in  NLAYERS*WIDTH: layer i data at bits [i*WIDTH +: WIDTH].
- `hm_last`  in  NLAYERS: layer i pointer is at its final hit, or layer i is empty.
- `hm_empty`  in  NLAYERS: layer i holds no hits.
- `hm_next`  out  NLAYERS: one-cycle pulse advancing layer i pointer by one.
- `hm_rewind`  out  NLAYERS: one-cycle pulse returning layer i pointer to its first hit.
- `comb_data`  out  NLAYERS*WIDTH: current combination, same packing as `hm_dout`.
- `comb_mask`  out  NLAYERS: 1 = layer i carries a wildcard; only ever nonzero with the Configuration macro.
- `comb_valid`  out  1: combination present.
- `comb_last`  out  1: final combination of the event; qualified by `comb_valid`.
- `comb_ready`  in  1: consumer accepts the beat.
- `busy`  out  1: high from the cycle after `start` until the cycle DONE is entered.
- `done`  out  1: one-cycle pulse at event end.
- `trunc`  out  1: sticky per event; cap reached. Cleared on `start`.
- `ncomb`  out  16: combinations emitted this event; saturating.

## Operation
- States: IDLE, REWIND, SETTLE, EMIT, ADVANCE, DONE.
- **IDLE**
  - On `start`: clear `ncomb` and `trunc`, then go to REWIND.
  - `start` is ignored in every other state.
- **REWIND**
  - Pulse `hm_rewind` on all layers for 1 cycle, then go to SETTLE.
- **Empty-layer check** (once, at the first SETTLE exit after REWIND):
  - If any `hm_empty` bit is set, go to DONE with zero combinations emitted.
- **SETTLE**
  - Count `SETTLE` cycles, then go to EMIT.
- **EMIT**
  - Register `hm_dout` into `comb_data` and assert `comb_valid`.
  - `comb_last` = AND of all `hm_last`, or `ncomb`==MAXCOMB-1.
  - Hold all outputs stable until `comb_valid & comb_ready`.
  - On accept, increment `ncomb`.
  - If the beat was `comb_last`: go to DONE, and set `trunc` if the cap caused it.
  - Otherwise go to ADVANCE.
- **ADVANCE**
  - Layer 0 varies fastest.
  - Let k = the lowest layer with `hm_last[k]`=0.
  - Pulse `hm_next[k]` and `hm_rewind[j]` for all j<k in the same cycle, then go to SETTLE.
- **DONE**
  - Pulse `done` for 1 cycle, then go to IDLE.
- **Arithmetic**
  - `ncomb` saturates at 16'hFFFF.
  - `MAXCOMB` ≤ 65535.

## Timing
- Reset values: all outputs 0; `comb_data` = 0; state = IDLE.
- Reset mid-event:
  - Outputs read 0 in the cycle after `reset` is sampled high.
  - No `hm_next`/`hm_rewind` pulse is issued after that point.
  - A pending beat is dropped.
- Minimum cycles per combination = SETTLE + 2 (ADVANCE + EMIT), with `comb_ready` held high.
- `start` → first `comb_valid` = SETTLE + 2 cycles (REWIND, SETTLE×SETTLE, EMIT register).
- `hm_next` and `hm_rewind` are never high on the same layer in the same cycle.
- At most one `hm_next` bit is high in any cycle.
- `done` follows the accept of the `comb_last` beat by exactly 1 cycle.
- In the empty-layer abort, `done` comes 1 cycle after the check.
- `comb_ready` may be held high continuously; it is ignored while `comb_valid`=0.

## Configuration
- `HITCOMB_WILDCARD_EN`
  - Defined: empty layers do not abort the event.
    - Each empty layer contributes `comb_data` slice = 0 with `comb_mask[i]`=1.
    - Its `hm_last` is treated as 1, so it never advances.
    - All layers empty → exactly one all-wildcard beat with `comb_last`=1.
  - Undefined:
    - Any empty layer → zero beats and a `done` pulse.
    - `comb_mask` is tied to 0.

## Test plan
- Hit counts 1,1,1,1,1,1; ready high → one beat, `comb_last`=1, `ncomb`=1; `done` 1 cycle after accept; first valid at cycle 4 after `start` (SETTLE=2).
- Hit counts 2,3,1,1,1,1 → 6 beats; layer 0 varies fastest: (0,0),(1,0),(0,1),(1,1),(0,2),(1,2); only the 6th beat has `comb_last`; `ncomb`=6.
- Layer 3 empty, others 2 hits; macro undefined → 0 beats, `done` pulse, `ncomb`=0. Macro defined → 32 beats, every beat `comb_mask`=6'b001000 and slice 3 = 0.
- MAXCOMB=4, hit counts 3,3,1,1,1,1 → 4 beats, 4th beat has `comb_last`; `trunc`=1; next `start` clears `trunc`.
- `comb_ready` low for 5 cycles on beat 2 → `comb_data`/`comb_valid` stable; no `hm_next` during the stall.
- `reset` asserted during SETTLE of beat 3 → all outputs 0 next cycle; subsequent `start` restarts cleanly from the first combination.
